// File: rtl/input_window_fetch.sv
// input_window_fetch: reads a zero-padded KERNEL x KERNEL pixel window from sync SRAM per request.
// Define WINDOW_REUSE_EN to shift the previous window and fetch one column on a +1 width step.
module input_window_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL     = 3,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int WIDTH_LOG  = 3,
  parameter int HEIGHT_LOG = 3,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 input_req,
  input  logic [WIDTH_LOG-1:0]                 width_index,
  input  logic [HEIGHT_LOG-1:0]                height_index,
  output logic                                 mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  input  logic [DATA_WIDTH-1:0]                mem_rd_data,
  output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  window_data,
  output logic                                 input_ready
);
  localparam int NSLOT = KERNEL*KERNEL;
  localparam int KW = $clog2(NSLOT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, READY, WAIT_DROP} state_t;

  state_t state, state_n;
  logic [WIDTH_LOG-1:0]  w_q;
  logic [HEIGHT_LOG-1:0] h_q;
  logic [KW-1:0]         k;
  logic                  pend;
  logic [KW-1:0]         pend_slot;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NSLOT*DATA_WIDTH-1:0] win;
  logic                  reuse_q;
  logic                  in_b, last;
  int                    kr, kc, row, col, slot;

  assign window_data = win;

  // In reuse mode k walks rows of the rightmost column only
  always_comb begin
    kr = reuse_q ? int'(k) : int'(k) / KERNEL;
    kc = reuse_q ? KERNEL - 1 : int'(k) % KERNEL;
    row = int'(h_q) + kr;
    col = int'(w_q) + kc;
    slot = kr*KERNEL + kc;
    in_b = row < IMG_HEIGHT && col < IMG_WIDTH;
    last = int'(k) == (reuse_q ? KERNEL - 1 : NSLOT - 1);
    mem_rd_en = state == FETCH && in_b;
    mem_addr = mem_rd_en ? ADDR_WIDTH'(row*IMG_WIDTH + col) : addr_q;
    input_ready = state == READY;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = input_req ? FETCH : IDLE;
      FETCH:     state_n = last ? DRAIN : FETCH;
      DRAIN:     state_n = READY;
      READY:     state_n = WAIT_DROP;
      WAIT_DROP: state_n = input_req ? WAIT_DROP : IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

`ifdef WINDOW_REUSE_EN
  logic                  prev_v;
  logic [WIDTH_LOG-1:0]  prev_w;
  logic [HEIGHT_LOG-1:0] prev_h;
  logic                  hit;

  assign hit = prev_v && height_index == prev_h && int'(width_index) == int'(prev_w) + 1;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_v <= 1'b0;
      prev_w <= '0;
      prev_h <= '0;
      reuse_q <= 1'b0;
    end else begin
      if (state == IDLE && input_req) reuse_q <= hit;
      if (state == READY) begin
        prev_v <= 1'b1;
        prev_w <= w_q;
        prev_h <= h_q;
      end
    end
  end
`else
  assign reuse_q = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      w_q <= '0;
      h_q <= '0;
      k <= '0;
      pend <= 1'b0;
      pend_slot <= '0;
      addr_q <= '0;
      win <= '0;
    end else begin
      addr_q <= mem_addr;
      pend <= mem_rd_en;
      pend_slot <= KW'(slot);
      if (pend) win[int'(pend_slot)*DATA_WIDTH +: DATA_WIDTH] <= mem_rd_data;
      if (state == IDLE && input_req) begin
        w_q <= width_index;
        h_q <= height_index;
        k <= '0;
`ifdef WINDOW_REUSE_EN
        if (hit)
          for (int r = 0; r < KERNEL; r++)
            for (int c = 0; c < KERNEL - 1; c++)
              win[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] <= win[(r*KERNEL+c+1)*DATA_WIDTH +: DATA_WIDTH];
`endif
      end
      if (state == FETCH) begin
        k <= k + KW'(1);
        if (!in_b) win[slot*DATA_WIDTH +: DATA_WIDTH] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_input_window_fetch.sv
// tb_input_window_fetch: scoreboard bench for input_window_fetch with an 8x8 sync SRAM model.
module tb_input_window_fetch;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        input_req = 1'b0;
  logic [2:0]  width_index = '0;
  logic [2:0]  height_index = '0;
  logic        mem_rd_en;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_rd_data;
  logic [71:0] window_data;
  logic        input_ready;

  logic [7:0]  sram [64];
  logic [5:0]  exp_addr [$];
  logic [71:0] exp_win [$];
  int checks = 0, errors = 0, pulses = 0, exp_pulses = 0;

  input_window_fetch dut (
    .clock(clock), .reset(reset), .input_req(input_req),
    .width_index(width_index), .height_index(height_index),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .window_data(window_data), .input_ready(input_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_rd_en) mem_rd_data <= sram[mem_addr];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) if (!reset) begin
    if (mem_rd_en) begin
      if (exp_addr.size() == 0) check("rd_extra", {71'b0, mem_rd_en}, 72'd0);
      else check("rd_addr", {66'b0, mem_addr}, {66'b0, exp_addr.pop_front()});
    end
    if (input_ready) begin
      pulses++;
      if (exp_win.size() == 0) check("ready_extra", {71'b0, input_ready}, 72'd0);
      else check("window", window_data, exp_win.pop_front());
    end
  end

  function automatic logic [71:0] win_at(input int h, input int w);
    logic [71:0] v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (h + r < 8 && w + c < 8) v[(r*3+c)*8 +: 8] = sram[(h+r)*8 + w + c];
    return v;
  endfunction

  task automatic push_full(input int h, input int w);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (h + r < 8 && w + c < 8) exp_addr.push_back(6'((h+r)*8 + w + c));
    exp_win.push_back(win_at(h, w));
  endtask

  task automatic push_reuse(input int h, input int w);
    for (int r = 0; r < 3; r++)
      if (h + r < 8 && w + 2 < 8) exp_addr.push_back(6'((h+r)*8 + w + 2));
    exp_win.push_back(win_at(h, w));
  endtask

  task automatic run_req(input int h, input int w, input int drop_k, input int lat);
    int n = 0;
    @(negedge clock);
    height_index = 3'(h);
    width_index = 3'(w);
    input_req = 1'b1;
    exp_pulses++;
    do begin
      @(posedge clock);
      n++;
      #1;
      if (n == drop_k + 1) input_req = 1'b0;
    end while (!input_ready && n < 40);
    check("latency", 72'(n - 1), 72'(lat));
    @(negedge clock);
    #1;
    check("pulses", 72'(pulses), 72'(exp_pulses));
    check("addr_left", 72'(exp_addr.size()), 72'd0);
  endtask

  task automatic release_req();
    input_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, {71'b0, mem_rd_en}, 72'd0);
    check({tag, "_addr"}, {66'b0, mem_addr}, 72'd0);
    check({tag, "_window"}, window_data, 72'd0);
    check({tag, "_ready"}, {71'b0, input_ready}, 72'd0);
  endtask

  initial begin
    for (int a = 0; a < 64; a++) sram[a] = 8'(a);
    sram[63] = 8'hAA;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    push_full(0, 0);
    run_req(0, 0, -1, 10);
    repeat (5) begin
      @(negedge clock);
      check("hold_rd_en", {71'b0, mem_rd_en}, 72'd0);
      check("hold_ready", {71'b0, input_ready}, 72'd0);
    end
    release_req();
`ifdef WINDOW_REUSE_EN
    push_reuse(0, 1);
    run_req(0, 1, -1, 4);
`else
    push_full(0, 1);
    run_req(0, 1, -1, 10);
`endif
    release_req();
    push_full(1, 1);
    run_req(1, 1, -1, 10);
    release_req();
    push_full(7, 7);
    run_req(7, 7, -1, 10);
    release_req();
    push_full(0, 0);
    @(negedge clock);
    height_index = 3'd0;
    width_index = 3'd0;
    input_req = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    input_req = 1'b0;
    check("k4_addr", {66'b0, mem_addr}, 72'd9);
    @(posedge clock);
    #1;
    exp_addr.delete();
    exp_win.delete();
    check_zero("midreset");
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    #1;
    check("midreset_no_pulse", 72'(pulses), 72'(exp_pulses));
    push_full(2, 3);
    run_req(2, 3, -1, 10);
    release_req();
    push_full(3, 4);
    run_req(3, 4, 2, 10);
    release_req();
    repeat (3) begin
      @(negedge clock);
      check("drop_idle_ready", {71'b0, input_ready}, 72'd0);
    end
    push_full(5, 0);
    run_req(5, 0, -1, 10);
    release_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
